proc_hazard_scoreboard: RTL
===========================

// Module: proc_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/bypass control for the TinyRV1 5-stage pipeline (F D X M W), decoupled from decode.
//  Tracks in-flight writes in X/M/W, generates D-stage stall and operand-bypass selects, and supports an
//  iterative multiplier that occupies X for MUL_LAT cycles. Sits between the decode logic and the datapath,
//  replacing the fixed single-cycle hazard logic of the previous control unit.
// PARAMETERS
//  NREGS    32  architectural register count; AW = $clog2(NREGS)
//  MUL_LAT  4   cycles a MUL occupies X (legal 1..16); 1 = single-cycle multiply
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  d_val        in   1   valid instruction in D
//  d_rs1_en     in   1   D instruction reads rs1
//  d_rs1        in   AW  rs1 address
//  d_rs2_en     in   1   D instruction reads rs2
//  d_rs2        in   AW  rs2 address
//  d_wen        in   1   D instruction writes RF
//  d_waddr      in   AW  rd address
//  d_is_lw      in   1   D instruction is LW
//  d_is_mul     in   1   D instruction is MUL
//  squash_D     in   1   kill D this cycle (taken branch in X)
//  stall_D      out  1   hold F and D registers
//  issue_X      out  1   D instruction enters X this cycle
//  mul_start_X  out  1   one-cycle pulse: multiplier begins (first X cycle of a MUL)
//  x_busy       out  1   X holding a multi-cycle MUL (not in final cycle)
//  op1_byp_sel  out  2   0 RF, 1 X, 2 M, 3 W
//  op2_byp_sel  out  2   as op1_byp_sel for rs2
//  rf_wen_W     out  1   RF write enable
//  rf_waddr_W   out  AW  RF write address
// BEHAVIOUR
//  - State per stage X/M/W: val, wen, waddr, is_lw; X also is_mul and cnt [$clog2(MUL_LAT+1)-1:0].
//  - Reset (rst=0, async): all val=0, cnt=0 -> stall_D=0, issue_X=0, mul_start_X=0, x_busy=0,
//    byp sels=0, rf_wen_W=0, rf_waddr_W=0. Reset mid-MUL abandons it; no write reaches W.
//  - Entries with waddr==0 are treated as wen=0 everywhere (no bypass, no stall, no RF write).
//  - x_busy = x_val & x_is_mul & (cnt!=0). x_done = ~x_busy.
//  - Load-use: luse = x_val & x_is_lw & x_wen & ((d_rs1_en & d_rs1==x_waddr) | (d_rs2_en & d_rs2==x_waddr)).
//  - stall_D = d_val & (luse | x_busy). Combinational.
//  - issue_X = d_val & ~stall_D & ~squash_D. squash_D wins over stall (D killed, F/D not held for it).
//  - X update, only when x_done: X <= D fields with val=issue_X; on issue of MUL, cnt <= MUL_LAT-1.
//    While x_busy: X holds, cnt decrements by 1 per cycle.
//  - mul_start_X = registered: 1 in the first cycle a MUL is valid in X. MUL_LAT=1: cnt loads 0, never busy.
//  - M <= X when x_done (val=x_val); M <= bubble (val=0) while x_busy. W <= M every cycle.
//  - Bypass rs1 (rs2 identical): candidate stage s valid if s_val & s_wen & d_rs1_en & d_val & addr match.
//    X candidate additionally requires ~x_is_lw & x_done. Priority X(1) > M(2) > W(3) > RF(0).
//    Sels are 0 whenever d_val=0.
//  - rf_wen_W = w_val & w_wen; rf_waddr_W = w_waddr (0 when w_val=0).
//  - Latency: single-cycle op issued at cycle t writes RF at t+3; MUL at t+MUL_LAT+2; LW consumer stalls 1 cycle.
//  - Simultaneous squash_D and x_busy: cannot occur (branches are never MUL); if driven, D is discarded, X still holds.
// TESTING
//  1 Reset mid-MUL (MUL_LAT=4, cnt=2): rst low -> all outputs 0 immediately; after release rf_wen_W stays 0.
//  2 ADD x3 issued t0, ADD rs1=x3 t1 -> op1_byp_sel=1 at t1; same consumer at t2/t3 -> 2 / 3; at t4 -> 0.
//  3 LW x5 then ADD rs2=x5 -> stall_D=1 one cycle, issue_X=0, then op2_byp_sel=2, issue_X=1.
//  4 MUL x7 (MUL_LAT=4), dependent ADD rs1=x7 -> stall_D=1 for 3 cycles, mul_start_X pulses once,
//    then op1_byp_sel=1; rf_wen_W=1, rf_waddr_W=7 at t+6; three M bubbles observed.
//  5 MUL_LAT=1 build: back-to-back MULs x1,x2 -> no stall, x_busy never 1, writes at t+3 and t+4.
//  6 ADDI x0 then reader of x0 -> sels 0, stall_D=0, rf_wen_W=0; squash_D with d_val=1 -> issue_X=0.

Source files
------------

// File: rtl/proc_hazard_scoreboard.sv
// rtl/proc_hazard_scoreboard.sv - hazard, stall and operand-bypass scoreboard for a 5-stage pipeline
module proc_hazard_scoreboard #(
    parameter int NREGS   = 32,
    parameter int MUL_LAT = 4,
    localparam int AW     = $clog2(NREGS),
    localparam int CW     = $clog2(MUL_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_val,
    input  logic          d_rs1_en,
    input  logic [AW-1:0] d_rs1,
    input  logic          d_rs2_en,
    input  logic [AW-1:0] d_rs2,
    input  logic          d_wen,
    input  logic [AW-1:0] d_waddr,
    input  logic          d_is_lw,
    input  logic          d_is_mul,
    input  logic          squash_D,
    output logic          stall_D,
    output logic          issue_X,
    output logic          mul_start_X,
    output logic          x_busy,
    output logic [1:0]    op1_byp_sel,
    output logic [1:0]    op2_byp_sel,
    output logic          rf_wen_W,
    output logic [AW-1:0] rf_waddr_W
);

    logic          r_x_val;
    logic          r_x_wen;
    logic [AW-1:0] r_x_waddr;
    logic          r_x_is_lw;
    logic          r_x_is_mul;
    logic [CW-1:0] r_x_cnt;
    logic          r_mul_start;

    logic          r_m_val;
    logic          r_m_wen;
    logic [AW-1:0] r_m_waddr;
    logic          r_m_is_lw;

    logic          r_w_val;
    logic          r_w_wen;
    logic [AW-1:0] r_w_waddr;

    logic          w_x_busy;
    logic          w_x_done;
    logic          w_luse;
    logic          w_stall;
    logic          w_issue;
    logic          w_d_wen;
    logic          w_x_fwd_ok;
    logic          w_m_fwd_ok;
    logic          w_w_fwd_ok;
    logic [1:0]    w_op1_sel;
    logic [1:0]    w_op2_sel;

    // x0 writes are dropped at entry so no later stage ever sees them as producers
    assign w_d_wen  = d_wen & (d_waddr != '0);

    assign w_x_busy = r_x_val & r_x_is_mul & (r_x_cnt != '0);
    assign w_x_done = ~w_x_busy;

    assign w_luse = r_x_val & r_x_is_lw & r_x_wen &
                    ((d_rs1_en & (d_rs1 == r_x_waddr)) |
                     (d_rs2_en & (d_rs2 == r_x_waddr)));

    assign w_stall = d_val & (w_luse | w_x_busy);
    assign w_issue = d_val & ~w_stall & ~squash_D;

    // Load data is not ready in X, and a MUL result only exists in its final X cycle
    assign w_x_fwd_ok = r_x_val & r_x_wen & ~r_x_is_lw & w_x_done;
    assign w_m_fwd_ok = r_m_val & r_m_wen;
    assign w_w_fwd_ok = r_w_val & r_w_wen;

    function automatic logic [1:0] byp_sel(
        input logic          rs_en,
        input logic [AW-1:0] rs,
        input logic          vld,
        input logic          x_ok,
        input logic [AW-1:0] x_addr,
        input logic          m_ok,
        input logic [AW-1:0] m_addr,
        input logic          w_ok,
        input logic [AW-1:0] w_addr
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (vld && rs_en) begin
            if (x_ok && (rs == x_addr)) begin
                sel = 2'd1;
            end else if (m_ok && (rs == m_addr)) begin
                sel = 2'd2;
            end else if (w_ok && (rs == w_addr)) begin
                sel = 2'd3;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_op1_sel = byp_sel(d_rs1_en, d_rs1, d_val,
                            w_x_fwd_ok, r_x_waddr,
                            w_m_fwd_ok, r_m_waddr,
                            w_w_fwd_ok, r_w_waddr);
        w_op2_sel = byp_sel(d_rs2_en, d_rs2, d_val,
                            w_x_fwd_ok, r_x_waddr,
                            w_m_fwd_ok, r_m_waddr,
                            w_w_fwd_ok, r_w_waddr);
    end

    // X stage: reloads from D only when the current occupant is finishing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_val     <= 1'b0;
            r_x_wen     <= 1'b0;
            r_x_waddr   <= '0;
            r_x_is_lw   <= 1'b0;
            r_x_is_mul  <= 1'b0;
            r_x_cnt     <= '0;
            r_mul_start <= 1'b0;
        end else if (w_x_done) begin
            r_x_val     <= w_issue;
            r_x_wen     <= w_d_wen;
            r_x_waddr   <= d_waddr;
            r_x_is_lw   <= d_is_lw;
            r_x_is_mul  <= d_is_mul;
            r_x_cnt     <= (w_issue & d_is_mul) ? CW'(MUL_LAT - 1) : '0;
            r_mul_start <= w_issue & d_is_mul;
        end else begin
            r_x_cnt     <= r_x_cnt - CW'(1);
            r_mul_start <= 1'b0;
        end
    end

    // M stage: bubbles are inserted behind a multiplier still iterating in X
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_val   <= 1'b0;
            r_m_wen   <= 1'b0;
            r_m_waddr <= '0;
            r_m_is_lw <= 1'b0;
        end else if (w_x_done) begin
            r_m_val   <= r_x_val;
            r_m_wen   <= r_x_wen;
            r_m_waddr <= r_x_waddr;
            r_m_is_lw <= r_x_is_lw;
        end else begin
            r_m_val   <= 1'b0;
            r_m_wen   <= 1'b0;
            r_m_waddr <= '0;
            r_m_is_lw <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_val   <= 1'b0;
            r_w_wen   <= 1'b0;
            r_w_waddr <= '0;
        end else begin
            r_w_val   <= r_m_val;
            r_w_wen   <= r_m_wen;
            r_w_waddr <= r_m_waddr;
        end
    end

    assign stall_D     = w_stall;
    assign issue_X     = w_issue;
    assign mul_start_X = r_mul_start;
    assign x_busy      = w_x_busy;
    assign op1_byp_sel = w_op1_sel;
    assign op2_byp_sel = w_op2_sel;
    assign rf_wen_W    = r_w_val & r_w_wen;
    assign rf_waddr_W  = r_w_val ? r_w_waddr : '0;

endmodule
